// File: rtl/mc_cpu.sv
// mc_cpu: multi-cycle core for the ADDI/ADD/SUB/LW/SW/BNE/JAL subset of RV32I.
// Define MC_CPU_PERF_CNT_EN to add 64-bit cycle and retired-instruction counters.
module mc_cpu #(
  parameter int              XLEN        = 32,
  parameter int              NUM_REGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              MEM_TIMEOUT = 15
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            halt_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_valid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_valid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            error_o,
  output logic            halted_o
`ifdef MC_CPU_PERF_CNT_EN
  ,
  output logic [63:0]     cycle_cnt_o,
  output logic [63:0]     instret_cnt_o
`endif
);

  localparam int              RIDX = $clog2(NUM_REGS);
  localparam int              CW   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0]   TMO  = CW'(MEM_TIMEOUT);
  localparam logic [5:0]      NREG = 6'(NUM_REGS);
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  typedef enum logic [2:0] {ST_FETCH, ST_EXEC, ST_MEM, ST_HALT, ST_ERROR} state_t;

  state_t          r_state, w_nextState;
  logic [XLEN-1:0] r_pc, r_memAddr, r_storeData;
  logic [31:0]     r_instr;
  logic [CW-1:0]   r_waitCnt;
  logic [XLEN-1:0] r_regs [NUM_REGS];

  logic [6:0]      w_opcode, w_f7;
  logic [4:0]      w_rd, w_rs1, w_rs2;
  logic [2:0]      w_f3;
  logic            w_isAddi, w_isR, w_isLoad, w_isStore, w_isBne, w_isJal, w_legal;
  logic            w_useRd, w_useRs1, w_useRs2, w_badReg;
  logic [XLEN-1:0] w_rs1Val, w_rs2Val, w_immI, w_immS, w_immB, w_immJ;
  logic [XLEN-1:0] w_memAddr, w_pcPlus4, w_aluRes, w_execNextPc, w_rdData;
  logic            w_latchInstr, w_pcLoad, w_memLatch, w_rdWe, w_waitInc, w_retire;

  assign w_opcode = r_instr[6:0];
  assign w_rd     = r_instr[11:7];
  assign w_f3     = r_instr[14:12];
  assign w_rs1    = r_instr[19:15];
  assign w_rs2    = r_instr[24:20];
  assign w_f7     = r_instr[31:25];

  assign w_isAddi  = (w_opcode == 7'b0010011) && (w_f3 == 3'b000);
  assign w_isR     = (w_opcode == 7'b0110011) && (w_f3 == 3'b000) &&
                     ((w_f7 == 7'b0000000) || (w_f7 == 7'b0100000));
  assign w_isLoad  = (w_opcode == 7'b0000011) && (w_f3 == 3'b010);
  assign w_isStore = (w_opcode == 7'b0100011) && (w_f3 == 3'b010);
  assign w_isBne   = (w_opcode == 7'b1100011) && (w_f3 == 3'b001);
  assign w_isJal   = (w_opcode == 7'b1101111);
  assign w_legal   = w_isAddi | w_isR | w_isLoad | w_isStore | w_isBne | w_isJal;

  // Only the register fields an instruction actually uses are range-checked
  assign w_useRd  = w_isAddi | w_isR | w_isLoad | w_isJal;
  assign w_useRs1 = w_isAddi | w_isR | w_isLoad | w_isStore | w_isBne;
  assign w_useRs2 = w_isR | w_isStore | w_isBne;
  assign w_badReg = (w_useRd  && ({1'b0, w_rd}  >= NREG)) ||
                    (w_useRs1 && ({1'b0, w_rs1} >= NREG)) ||
                    (w_useRs2 && ({1'b0, w_rs2} >= NREG));

  assign w_rs1Val = (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1[RIDX-1:0]];
  assign w_rs2Val = (w_rs2 == 5'd0) ? '0 : r_regs[w_rs2[RIDX-1:0]];

  assign w_immI = {{(XLEN-12){r_instr[31]}}, r_instr[31:20]};
  assign w_immS = {{(XLEN-12){r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
  assign w_immB = {{(XLEN-13){r_instr[31]}}, r_instr[31], r_instr[7],
                   r_instr[30:25], r_instr[11:8], 1'b0};
  assign w_immJ = {{(XLEN-21){r_instr[31]}}, r_instr[31], r_instr[19:12],
                   r_instr[20], r_instr[30:21], 1'b0};

  assign w_memAddr    = w_rs1Val + (w_isStore ? w_immS : w_immI);
  assign w_pcPlus4    = r_pc + FOUR;
  assign w_aluRes     = w_isJal      ? w_pcPlus4 :
                        w_isAddi     ? w_rs1Val + w_immI :
                        r_instr[30]  ? w_rs1Val - w_rs2Val : w_rs1Val + w_rs2Val;
  assign w_execNextPc = w_isJal                          ? r_pc + w_immJ :
                        (w_isBne && (w_rs1Val != w_rs2Val)) ? r_pc + w_immB : w_pcPlus4;

  always_comb begin
    w_nextState  = r_state;
    w_latchInstr = 1'b0;
    w_pcLoad     = 1'b0;
    w_memLatch   = 1'b0;
    w_rdWe       = 1'b0;
    w_rdData     = w_aluRes;
    w_waitInc    = 1'b0;
    w_retire     = 1'b0;
    case (r_state)
      ST_FETCH: begin
        if (imem_valid_i) begin
          w_latchInstr = 1'b1;
          w_nextState  = ST_EXEC;
        end else if (halt_i && (r_waitCnt == '0)) begin
          w_nextState = ST_HALT;
        end else if (r_waitCnt == TMO) begin
          w_nextState = ST_ERROR;
        end else begin
          w_waitInc = 1'b1;
        end
      end
      ST_EXEC: begin
        if (!w_legal || w_badReg) begin
          w_nextState = ST_ERROR;
        end else if (w_isLoad || w_isStore) begin
          if (w_memAddr[1:0] != 2'b00) begin
            w_nextState = ST_ERROR;
          end else begin
            w_memLatch  = 1'b1;
            w_pcLoad    = 1'b1;
            w_nextState = ST_MEM;
          end
        end else if (w_execNextPc[1:0] != 2'b00) begin
          w_nextState = ST_ERROR;
        end else begin
          w_pcLoad    = 1'b1;
          w_rdWe      = !w_isBne;
          w_retire    = 1'b1;
          w_nextState = halt_i ? ST_HALT : ST_FETCH;
        end
      end
      ST_MEM: begin
        if (dmem_valid_i) begin
          w_rdWe      = w_isLoad;
          w_rdData    = dmem_rdata_i;
          w_retire    = 1'b1;
          w_nextState = halt_i ? ST_HALT : ST_FETCH;
        end else if (r_waitCnt == TMO) begin
          w_nextState = ST_ERROR;
        end else begin
          w_waitInc = 1'b1;
        end
      end
      ST_HALT: begin
        if (!halt_i) w_nextState = ST_FETCH;
      end
      ST_ERROR: w_nextState = ST_ERROR;
      default:  w_nextState = ST_ERROR;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_FETCH;
      r_pc        <= RESET_PC;
      r_instr     <= '0;
      r_memAddr   <= '0;
      r_storeData <= '0;
      r_waitCnt   <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_state   <= w_nextState;
      r_waitCnt <= w_waitInc ? r_waitCnt + 1'b1 : '0;
      if (w_latchInstr) r_instr <= imem_rdata_i;
      if (w_pcLoad) r_pc <= w_execNextPc;
      if (w_memLatch) begin
        r_memAddr   <= w_memAddr;
        r_storeData <= w_rs2Val;
      end
      if (w_rdWe && (w_rd != 5'd0)) r_regs[w_rd[RIDX-1:0]] <= w_rdData;
    end
  end

  // Fetch request is masked during reset because the reset state is FETCH
  assign imem_req_o   = (r_state == ST_FETCH) && !rst_i;
  assign imem_addr_o  = r_pc;
  assign dmem_req_o   = (r_state == ST_MEM);
  assign dmem_we_o    = (r_state == ST_MEM) && w_isStore;
  assign dmem_addr_o  = r_memAddr;
  assign dmem_wdata_o = r_storeData;
  assign error_o      = (r_state == ST_ERROR);
  assign halted_o     = (r_state == ST_HALT);

`ifdef MC_CPU_PERF_CNT_EN
  logic [63:0] r_cycleCnt, r_instretCnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cycleCnt   <= '0;
      r_instretCnt <= '0;
    end else begin
      if ((r_state != ST_HALT) && (r_state != ST_ERROR)) r_cycleCnt <= r_cycleCnt + 64'd1;
      if (w_retire) r_instretCnt <= r_instretCnt + 64'd1;
    end
  end

  assign cycle_cnt_o   = r_cycleCnt;
  assign instret_cnt_o = r_instretCnt;
`endif

endmodule

// File: doc/mc_cpu.md
MC_CPU -- requirements
Module: mc_cpu

Interface
REQ-001 Parameter XLEN, default 32: datapath, register, PC and memory address/data width; legal values are 32 and 64.
REQ-002 Parameter NUM_REGS, default 32: architectural register count; legal values are 16 and 32.
REQ-003 Parameter RESET_PC, default 0: PC value loaded on reset.
REQ-004 Parameter MEM_TIMEOUT, default 15: maximum wait cycles for a memory response before an error is raised.
REQ-005 Port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 Port rst_i, input, 1 bit: reset; one clock, reset is asynchronous and active-high.
REQ-007 Port halt_i, input, 1 bit: requests a stop at the next instruction boundary.
REQ-008 Port imem_req_o, input/output direction output, 1 bit: instruction fetch request.
REQ-009 Port imem_addr_o, output, XLEN bits: fetch address, equal to the PC.
REQ-010 Port imem_valid_i, input, 1 bit: the fetch response is present.
REQ-011 Port imem_rdata_i, input, 32 bits: the fetched instruction.
REQ-012 Ports dmem_req_o (output, 1 bit), dmem_we_o (output, 1 bit), dmem_addr_o (output, XLEN bits), dmem_wdata_o (output, XLEN bits): data memory request, write enable, address and store data.
REQ-013 Ports dmem_valid_i (input, 1 bit) and dmem_rdata_i (input, XLEN bits): data response and load data.
REQ-014 Port error_o, output, 1 bit: sticky fault flag.
REQ-015 Port halted_o, output, 1 bit: the core is stopped in the HALT state.

Function
REQ-016 The block SHALL execute these RV32I encodings and no others:
- ADDI (0010011/000)
- ADD/SUB (0110011/000, funct7 0000000 or 0100000)
- LW (0000011/010)
- SW (0100011/010)
- BNE (1100011/001)
- JAL (1101111)
REQ-017 FSM states SHALL be FETCH, EXEC, MEM, HALT and ERROR.
REQ-018 FETCH SHALL behave as follows:
- halt_i=1 with no request outstanding -> HALT.
- Otherwise imem_req_o=1 is held until imem_valid_i=1; the instruction is then latched and the state goes to EXEC.
- imem_valid_i is accepted in the same cycle as the request.
REQ-019 EXEC SHALL behave as follows:
- ALU, BNE and JAL instructions: write rd and update the PC, then -> FETCH.
- LW and SW: latch the address (rs1 + imm) and the store data, then -> MEM.
REQ-020 MEM SHALL hold dmem_req_o=1, with dmem_we_o=1 for SW, until dmem_valid_i=1; LW then writes dmem_rdata_i to rd; the state goes to FETCH.
REQ-021 Latency with zero-wait memory SHALL be 2 cycles for ALU, BNE and JAL, and 3 cycles for LW and SW; each memory wait cycle adds 1.
REQ-022 Next PC SHALL be PC+4, or PC+imm (B- or J-format immediate, sign-extended) for a taken BNE or for JAL; arithmetic wraps modulo 2^XLEN.
REQ-023 JAL SHALL write PC+4 to rd.
REQ-024 ADD/SUB/ADDI results SHALL wrap modulo 2^XLEN with no overflow flag; immediates are sign-extended to XLEN.
REQ-025 Register x0 SHALL read 0, and writes to it SHALL be discarded; an instruction that reads rs1/rs2 and writes rd = rs1 SHALL use the old value.
REQ-026 Any of the following SHALL cause -> ERROR, with error_o=1 and all requests deasserted:
- an illegal encoding;
- a register index >= NUM_REGS;
- a next-PC or LW/SW address with bits [1:0] != 0;
- more than MEM_TIMEOUT cycles waiting for a valid response.
REQ-027 ERROR SHALL be left only by reset.
REQ-028 HALT SHALL set halted_o=1 and deassert all requests; when halt_i=0 it returns to FETCH; architectural state is unchanged while halted.
REQ-029 halt_i asserted during FETCH-with-request, EXEC or MEM SHALL take effect only after the instruction completes.
REQ-030 The request outputs SHALL be driven combinationally from the state only, with no combinational path from any *_valid_i to any *_req_o.

Reset
REQ-031 While rst_i=1, the block SHALL hold the following reset values:
- state = FETCH and PC = RESET_PC;
- all registers = 0;
- error_o=0, halted_o=0;
- imem_req_o=0, dmem_req_o=0, dmem_we_o=0;
- imem_addr_o = RESET_PC;
- dmem_addr_o = 0 and dmem_wdata_o = 0.
REQ-032 rst_i asserted mid-transaction SHALL abort it immediately; no register write or store completes, and the first request after release is a fetch from RESET_PC.

Configuration
REQ-033 Macro MC_CPU_PERF_CNT_EN defined SHALL add two ports and their counters:
- cycle_cnt_o (output, 64 bits): counts every cycle out of reset except in HALT and ERROR.
- instret_cnt_o (output, 64 bits): counts each completed instruction.
- Both counters reset to 0 and wrap at 2^64.
REQ-034 With MC_CPU_PERF_CNT_EN undefined, neither port nor counter SHALL exist, and behaviour is otherwise identical.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
- ADDI x1,x0,5; ADDI x2,x1,-7, zero-wait memory -> x2=0xFFFFFFFE; fetch 3 issued at cycle 4 from PC=8.
- SW x2,0x10(x0) then LW x3,0x10(x0), dmem_valid_i delayed 3 cycles -> store of 0xFFFFFFFE to address 0x10; x3=0xFFFFFFFE; each instruction takes 6 cycles.
- BNE x1,x0,-8 at PC=0x20 with x1=5 -> next fetch 0x18; with x1=0 -> next fetch 0x24; JAL x5,+0x100 at PC=0x24 -> x5=0x28, next fetch 0x124.
- Fetch of 0xFFFFFFFF -> error_o=1 the next cycle and no further requests; imem_valid_i held low for 16 cycles -> error_o=1.
- halt_i=1 during MEM of an LW -> the LW completes, then halted_o=1; rst_i pulsed during MEM -> no register write, and fetch restarts at RESET_PC.
- With MC_CPU_PERF_CNT_EN, 10 zero-wait ADDIs -> instret_cnt_o=10 and cycle_cnt_o=20.
